core_sequencer: RTL
===================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RV32 core datapath: fetch, decode, execute, data memory and register-file writeback.
- Streams a program from a host into instruction memory, then sequences each instruction through FETCH, EXEC, optional MEM and WB phases.
- Waits out the registered-output latency of both block RAMs.
- Replaces the free-running pc/instruction-load counter logic in the top level; owns pc, the latched instruction word and all datapath write enables.

Parameters:
- IMEM_DEPTH, 4096, instruction memory words; address width = $clog2(IMEM_DEPTH).
- MEM_LATENCY, 2, clock edges from RAM address sample to valid douta (HIGH_PERFORMANCE RAM).

Ports:
- clk_100mhz  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- start_in  in  1  run request, single-cycle pulse
- load_data_in  in  32  program word from host
- load_valid_in  in  1  host word valid
- load_last_in  in  1  final word of program, qualified by valid
- load_ready_out  out  1  sequencer accepts word
- imem_addr_out  out  12  instruction RAM address
- imem_we_out  out  1  instruction RAM write enable
- imem_din_out  out  32  instruction RAM write data
- inst_in  in  32  instruction RAM douta
- mem_op_in  in  2  from decoder: 00 none, 01 load, 10 store
- next_pc_in  in  32  from execute
- pc_out  out  32  current pc
- inst_out  out  32  latched instruction to decoder
- dmem_we_en_out  out  1  data RAM write enable, ANDed externally with store decode
- rf_we_en_out  out  1  register-file writeback strobe, ANDed externally with rd!=0 and type gating
- retired_out  out  32  retired instruction count
- load_count_out  out  13  words loaded
- state_out  out  3  current state encoding
- halted_out  out  1  in HALT
- err_out  out  1  misaligned-pc trap latched

Behaviour:
- Reset (rst_in=0, async): state IDLE; all outputs 0; prog_loaded cleared; RAM contents untouched. A reset mid-operation aborts immediately with no partial write completed.
- State encodings: IDLE=0, LOAD=1, FETCH=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE:
  - load_valid_in=1 -> LOAD; load_count and load_addr are cleared.
  - Otherwise start_in=1 with prog_loaded=1 -> FETCH with pc=0, retired=0, err=0.
  - start_in without a loaded program is ignored.
  - When load_valid_in and start_in are both high, load wins.
- LOAD:
  - load_ready_out=1.
  - Each valid&ready beat: imem_we_out=1 for that cycle, imem_addr_out=load_addr, imem_din_out=load_data_in; then load_addr++ and load_count++.
  - valid=0: no write, and load_ready_out holds 1.
  - A beat with load_last_in=1, or a beat at load_addr=IMEM_DEPTH-1, sets prog_loaded and -> IDLE. Further words are not accepted and there is no wrap-around.
- FETCH:
  - imem_addr_out=pc[13:2]; imem_we_out=0.
  - Lasts MEM_LATENCY+1 cycles, counted by an internal counter.
  - inst_in is captured into inst_out on the clock edge ending the last FETCH cycle, then -> EXEC.
- EXEC: one cycle for the combinational decode and execute to settle.
  - inst_out==32'h00000073 (ecall) or 32'h00100073 (ebreak) -> HALT; not counted as retired.
  - Else mem_op_in!=00 -> MEM.
  - Else -> WB.
- MEM:
  - Lasts MEM_LATENCY+1 cycles.
  - dmem_we_en_out=1 in the first MEM cycle only, and only when mem_op_in=10.
  - Then -> WB. Load data is valid at WB.
- WB: one cycle.
  - rf_we_en_out=1.
  - next_pc_in[1:0]!=0: err_out=1, pc unchanged, retired unchanged, -> HALT.
  - Else pc<=next_pc_in, retired_out++ (wraps at 2^32), -> FETCH.
- HALT:
  - halted_out=1.
  - start_in -> FETCH with pc=0, retired=0, err=0.
  - load_valid_in -> LOAD, clearing prog_loaded; load wins over start_in.
- Cycles per instruction with MEM_LATENCY=2: 5 without a memory op, 8 with one.
- rf_we_en_out and dmem_we_en_out are never asserted outside WB and MEM respectively.
- pc is 32-bit; imem addressing uses only pc[13:2], so a pc beyond the RAM aliases modulo 16 KiB.

Test Plan:
- Load 3 words (0x00158593, 0x00158593, 0x00000073) with last on word 3, valid held high -> imem writes at addresses 0, 1, 2 on 3 consecutive cycles; load_count_out=3; state returns to IDLE.
- After that load, pulse start_in -> HALT reached 5+5+4 cycles after FETCH entry; retired_out=2, halted_out=1, pc_out=8, rf_we_en_out high exactly 2 cycles.
- Load with load_valid_in toggling 1,0,1,0,1 and last on the 3rd beat -> exactly 3 writes at addresses 0..2, and none on valid=0 cycles.
- Program of sw then ecall, with mem_op_in=10 during the sw -> dmem_we_en_out high exactly 1 cycle; sw takes 8 cycles; retired_out=1 at halt.
- next_pc_in=0x00000006 at WB -> err_out=1, HALT, pc_out unchanged, retired_out unchanged.
- Deassert rst_in during EXEC -> state_out=0 and all outputs 0 before the next clock edge. start_in then has no effect until a new load.

Source files
------------

// File: rtl/core_seq_if.sv
// Host program-load stream and instruction RAM port of the core sequencer.
// The sequencer uses the slave modport; the host/RAM side uses master.
interface core_seq_if #(
   parameter int AW = 12
);
   logic [31:0]   load_data_in;
   logic          load_valid_in;
   logic          load_last_in;
   logic          load_ready_out;
   logic [AW-1:0] imem_addr_out;
   logic          imem_we_out;
   logic [31:0]   imem_din_out;
   logic [31:0]   inst_in;

   modport slave (
      input  load_data_in, load_valid_in, load_last_in, inst_in,
      output load_ready_out, imem_addr_out, imem_we_out, imem_din_out
   );
   modport master (
      output load_data_in, load_valid_in, load_last_in, inst_in,
      input  load_ready_out, imem_addr_out, imem_we_out, imem_din_out
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32 core: program load, then
// FETCH/EXEC/MEM/WB per instruction, waiting out block-RAM read latency.
module core_sequencer #(
   parameter int IMEM_DEPTH  = 4096,
   parameter int MEM_LATENCY = 2,
   localparam int AW = $clog2(IMEM_DEPTH)
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   input  logic        start_in,
   core_seq_if.slave   bus,
   input  logic [1:0]  mem_op_in,
   input  logic [31:0] next_pc_in,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        dmem_we_en_out,
   output logic        rf_we_en_out,
   output logic [31:0] retired_out,
   output logic [AW:0] load_count_out,
   output logic [2:0]  state_out,
   output logic        halted_out,
   output logic        err_out
);
   localparam int CW = $clog2(MEM_LATENCY + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);
   localparam logic [AW-1:0] ADDR_LAST = AW'(IMEM_DEPTH - 1);
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_EXEC  = 3'd3,
      S_MEM   = 3'd4,
      S_WB    = 3'd5,
      S_HALT  = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inst_q, inst_d;
   logic [31:0]   retired_q, retired_d;
   logic [AW:0]   load_count_q, load_count_d;
   logic [AW-1:0] load_addr_q, load_addr_d;
   logic          prog_loaded_q, prog_loaded_d;
   logic          err_q, err_d;

   always_ff @(posedge clk_100mhz or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pc_q          <= '0;
         inst_q        <= '0;
         retired_q     <= '0;
         load_count_q  <= '0;
         load_addr_q   <= '0;
         prog_loaded_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         retired_q     <= retired_d;
         load_count_q  <= load_count_d;
         load_addr_q   <= load_addr_d;
         prog_loaded_q <= prog_loaded_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      pc_d               = pc_q;
      inst_d             = inst_q;
      retired_d          = retired_q;
      load_count_d       = load_count_q;
      load_addr_d        = load_addr_q;
      prog_loaded_d      = prog_loaded_q;
      err_d              = err_q;
      bus.load_ready_out = 1'b0;
      bus.imem_we_out    = 1'b0;
      bus.imem_addr_out  = '0;
      bus.imem_din_out   = '0;
      dmem_we_en_out     = 1'b0;
      rf_we_en_out       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.load_valid_in) begin
               state_d      = S_LOAD;
               load_count_d = '0;
               load_addr_d  = '0;
            end else if (start_in && prog_loaded_q) begin
               state_d   = S_FETCH;
               cnt_d     = '0;
               pc_d      = '0;
               retired_d = '0;
               err_d     = 1'b0;
            end
         end
         S_LOAD: begin
            bus.load_ready_out = 1'b1;
            if (bus.load_valid_in) begin
               bus.imem_we_out   = 1'b1;
               bus.imem_addr_out = load_addr_q;
               bus.imem_din_out  = bus.load_data_in;
               load_addr_d       = load_addr_q + 1'b1;
               load_count_d      = load_count_q + 1'b1;
               // Last slot of the RAM ends the load; the address never wraps.
               if (bus.load_last_in || load_addr_q == ADDR_LAST) begin
                  prog_loaded_d = 1'b1;
                  state_d       = S_IDLE;
               end
            end
         end
         S_FETCH: begin
            bus.imem_addr_out = pc_q[AW+1:2];
            if (cnt_q == CNT_LAST) begin
               inst_d  = bus.inst_in;
               state_d = S_EXEC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EXEC: begin
            if (inst_q == ECALL || inst_q == EBREAK) begin
               state_d = S_HALT;
            end else if (mem_op_in != 2'b00) begin
               state_d = S_MEM;
               cnt_d   = '0;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_we_en_out = (cnt_q == '0) && (mem_op_in == 2'b10);
            if (cnt_q == CNT_LAST) state_d = S_WB;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_WB: begin
            rf_we_en_out = 1'b1;
            if (next_pc_in[1:0] != 2'b00) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               pc_d      = next_pc_in;
               retired_d = retired_q + 1'b1;
               cnt_d     = '0;
               state_d   = S_FETCH;
            end
         end
         S_HALT: begin
            if (bus.load_valid_in) begin
               state_d       = S_LOAD;
               prog_loaded_d = 1'b0;
               load_count_d  = '0;
               load_addr_d   = '0;
            end else if (start_in) begin
               state_d   = S_FETCH;
               cnt_d     = '0;
               pc_d      = '0;
               retired_d = '0;
               err_d     = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pc_out         = pc_q;
   assign inst_out       = inst_q;
   assign retired_out    = retired_q;
   assign load_count_out = load_count_q;
   assign state_out      = state_q;
   assign halted_out     = (state_q == S_HALT);
   assign err_out        = err_q;
endmodule
